// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake. Result registers hold until the next completion.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dz;

  logic [WIDTH:0]   w_rp;
  logic             w_ge;
  logic [WIDTH:0]   w_rnext;
  logic [WIDTH-1:0] w_qnext;

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  assign w_rp    = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_ge    = (w_rp >= {1'b0, r_div});
  assign w_rnext = w_ge ? (w_rp - {1'b0, r_div}) : w_rp;
  assign w_qnext = {r_q[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_q     <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_div <= divisor;
            if (divisor != '0) begin
              r_rem   <= '0;
              r_q     <= dividend;
              r_cnt   <= CW'(WIDTH);
              r_busy  <= 1'b1;
              r_state <= RUN;
            end else begin
              r_quot  <= '1;
              r_remo  <= dividend;
              r_dz    <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        RUN: begin
          r_rem <= w_rnext;
          r_q   <= w_qnext;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            // Flag is cleared here, not at start, so all results stay stable while busy.
            r_quot  <= w_qnext;
            r_remo  <= w_rnext[WIDTH-1:0];
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dz;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: handshake timing, boundaries, divide-by-zero,
// ignored restart, async reset, and an exhaustive multiply-back check.
module tb_seq_divider;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] last_q = 4'd0;
  logic [3:0] last_r = 4'd0;

  seq_divider #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // 4x4 shift-add array multiplier model used for the multiply-back check
  function automatic logic [7:0] mul4(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p = 8'd0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p + ({4'd0, a} << i);
    return p;
  endfunction

  // Full handshake check; called with inputs driven at a negedge.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] eq, input logic [3:0] er, input logic edz);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    if (b != 4'd0) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("busy %0d/%0d c%0d", a, b, i), {31'd0, busy}, 32'd1);
        chk($sformatf("nodone %0d/%0d c%0d", a, b, i), {31'd0, done}, 32'd0);
        chk($sformatf("holdq %0d/%0d c%0d", a, b, i), {28'd0, quotient}, {28'd0, last_q});
        chk($sformatf("holdr %0d/%0d c%0d", a, b, i), {28'd0, remainder}, {28'd0, last_r});
        @(negedge clk);
      end
    end
    chk($sformatf("done %0d/%0d", a, b), {31'd0, done}, 32'd1);
    chk($sformatf("busy_end %0d/%0d", a, b), {31'd0, busy}, 32'd0);
    chk($sformatf("quot %0d/%0d", a, b), {28'd0, quotient}, {28'd0, eq});
    chk($sformatf("rem %0d/%0d", a, b), {28'd0, remainder}, {28'd0, er});
    chk($sformatf("dz %0d/%0d", a, b), {31'd0, div_by_zero}, {31'd0, edz});
    @(negedge clk);
    chk($sformatf("pulse %0d/%0d", a, b), {31'd0, done}, 32'd0);
    last_q = eq; last_r = er;
  endtask

  // Lightweight run for the exhaustive sweep, with a bounded wait for done.
  task automatic run_quick(input logic [3:0] a, input logic [3:0] b);
    int cyc = 0;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) chk($sformatf("timeout %0d/%0d", a, b), 32'd0, 32'd1);
    else begin
      chk($sformatf("mulback %0d/%0d", a, b),
          {24'd0, mul4(quotient, b)} + {28'd0, remainder}, {28'd0, a});
      chk($sformatf("remlt %0d/%0d", a, b), {31'd0, remainder < b}, 32'd1);
    end
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quot", {28'd0, quotient}, 32'd0);
    chk("rst_rem", {28'd0, remainder}, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    do_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    do_op(4'd5, 4'd7, 4'd0, 4'd5, 1'b0);
    do_op(4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
    do_op(4'd0, 4'd6, 4'd0, 4'd0, 1'b0);
    do_op(4'd9, 4'd0, 4'd15, 4'd9, 1'b1);
    do_op(4'd8, 4'd2, 4'd4, 4'd0, 1'b0);

    // Restart during RUN must be ignored.
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd6; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        chk("restart_quot", {28'd0, quotient}, 32'd4);
        chk("restart_rem", {28'd0, remainder}, 32'd1);
      end
    end
    chk("restart_pulses", pulses, 32'd1);
    last_q = 4'd4; last_r = 4'd1;

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_quot", {28'd0, quotient}, 32'd0);
    chk("arst_rem", {28'd0, remainder}, 32'd0);
    chk("arst_dz", {31'd0, div_by_zero}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("arst_nodone", pulses, 32'd0);
    last_q = 4'd0; last_r = 4'd0;
    do_op(4'd12, 4'd4, 4'd3, 4'd0, 1'b0);

    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++)
        run_quick(4'(a), 4'(b));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
